// File: rtl/alu_mem_pkg.sv
// Shared definitions for the memory-mapped ALU initiator: register map,
// opcode and FSM state encodings, and the divide-by-zero result code.
package alu_mem_pkg;

  // Responder register map
  localparam int unsigned ADDR_A    = 0;
  localparam int unsigned ADDR_B    = 1;
  localparam int unsigned ADDR_OPER = 2;
  localparam int unsigned ADDR_EXEC = 3;

  // Values written to the EXEC register to start / stop an operation
  localparam logic [7:0] EXEC_SET = 8'h01;
  localparam logic [7:0] EXEC_CLR = 8'h00;

  // Result the responder returns for a divide by zero
  localparam logic [15:0] DIVZERO_CODE = 16'hDEAD;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_A     = 3'd1,
    ST_WR_B     = 3'd2,
    ST_WR_OP    = 3'd3,
    ST_WR_EXEC  = 3'd4,
    ST_WAIT     = 3'd5,
    ST_CLR_EXEC = 3'd6,
    ST_RESP     = 3'd7
  } state_e;

  // Opcodes 5..7 have no meaning on the responder and are rejected locally
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'(OP_DIV));
  endfunction

endpackage

// File: rtl/alu_mem_master.sv
// Bus initiator for the memory-mapped ALU responder. Takes one command,
// writes A, B, OPER and EXEC, waits for the registered result, clears EXEC
// and hands the result back on a valid/ready response channel.
// All bus and handshake outputs are registered: the next-state logic
// computes their values for the coming cycle alongside the next state.
module alu_mem_master
  import alu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int RES_WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [2:0]            cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_result,
  output logic                  rsp_divzero,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  mem_enable,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [RES_WIDTH-1:0]  mem_res_out
);

  // Wait counter counts RES_WAIT cycles: loaded with RES_WAIT-1, sampled at 0
  localparam logic [3:0] WAIT_LOAD = 4'(RES_WAIT - 1);

  state_e                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0] a_q, a_nxt;
  logic [DATA_WIDTH-1:0] b_q, b_nxt;
  logic [2:0]            op_q, op_nxt;
  logic [RES_WIDTH-1:0]  result_nxt;
  logic                  divzero_nxt;
  logic                  error_nxt;
  logic                  bus_en_nxt;
  logic                  bus_rd_wr_nxt;
  logic [ADDR_WIDTH-1:0] bus_addr_nxt;
  logic [DATA_WIDTH-1:0] bus_data_nxt;

  // Next state, captured command/result and next-cycle bus values
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    a_nxt         = a_q;
    b_nxt         = b_q;
    op_nxt        = op_q;
    result_nxt    = rsp_result;
    divzero_nxt   = rsp_divzero;
    error_nxt     = rsp_error;
    bus_en_nxt    = 1'b0;
    bus_rd_wr_nxt = 1'b1;
    bus_addr_nxt  = '0;
    bus_data_nxt  = '0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_nxt       = cmd_a;
          b_nxt       = cmd_b;
          op_nxt      = cmd_op;
          result_nxt  = '0;
          divzero_nxt = 1'b0;
          error_nxt   = 1'b0;
          if (op_is_legal(cmd_op)) begin
            // Operand A goes out in the cycle right after acceptance
            state_nxt     = ST_WR_A;
            bus_en_nxt    = 1'b1;
            bus_rd_wr_nxt = 1'b0;
            bus_addr_nxt  = ADDR_WIDTH'(ADDR_A);
            bus_data_nxt  = cmd_a;
          end else begin
            // Illegal opcode: answer immediately, never touch the bus
            state_nxt = ST_RESP;
            error_nxt = 1'b1;
          end
        end
      end
      ST_WR_A: begin
        state_nxt     = ST_WR_B;
        bus_en_nxt    = 1'b1;
        bus_rd_wr_nxt = 1'b0;
        bus_addr_nxt  = ADDR_WIDTH'(ADDR_B);
        bus_data_nxt  = b_q;
      end
      ST_WR_B: begin
        state_nxt     = ST_WR_OP;
        bus_en_nxt    = 1'b1;
        bus_rd_wr_nxt = 1'b0;
        bus_addr_nxt  = ADDR_WIDTH'(ADDR_OPER);
        bus_data_nxt  = DATA_WIDTH'(op_q);
      end
      ST_WR_OP: begin
        state_nxt     = ST_WR_EXEC;
        bus_en_nxt    = 1'b1;
        bus_rd_wr_nxt = 1'b0;
        bus_addr_nxt  = ADDR_WIDTH'(ADDR_EXEC);
        bus_data_nxt  = DATA_WIDTH'(EXEC_SET);
      end
      ST_WR_EXEC: begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          // Result has settled on the responder; capture it and clear EXEC
          result_nxt    = mem_res_out;
          divzero_nxt   = (op_q == OP_DIV) && (b_q == '0);
          state_nxt     = ST_CLR_EXEC;
          bus_en_nxt    = 1'b1;
          bus_rd_wr_nxt = 1'b0;
          bus_addr_nxt  = ADDR_WIDTH'(ADDR_EXEC);
          bus_data_nxt  = DATA_WIDTH'(EXEC_CLR);
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_CLR_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, captured data and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'd0;
      rsp_result  <= '0;
      rsp_divzero <= 1'b0;
      rsp_error   <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
      mem_enable  <= 1'b0;
      mem_rd_wr   <= 1'b1;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      op_q        <= op_nxt;
      rsp_result  <= result_nxt;
      rsp_divzero <= divzero_nxt;
      rsp_error   <= error_nxt;
      cmd_ready   <= (state_nxt == ST_IDLE);
      rsp_valid   <= (state_nxt == ST_RESP);
      busy        <= (state_nxt != ST_IDLE);
      mem_enable  <= bus_en_nxt;
      mem_rd_wr   <= bus_rd_wr_nxt;
      mem_addr    <= bus_addr_nxt;
      mem_wr_data <= bus_data_nxt;
    end
  end

endmodule
